// File: rtl/ppu_pkg.sv
// Purpose: shared PPU definitions: register indices, OAM DMA trigger address,
//          and the OAM DMA state encoding.
package ppu_pkg;

  // PPU register indices as seen on the 3-bit register address bus
  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUMASK   = 3'd1;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMADDR   = 3'd3;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  // CPU address whose write starts a sprite DMA
  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;

  localparam int unsigned DMA_IDX_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_t;

endpackage

// File: rtl/ppu_oam_dma_if.sv
// Purpose: bundle of CPU bus, work-RAM read port and PPU register port used by
//          the OAM DMA engine.
//   master : DMA side (drives cpu_rdy/dma_busy, RAM read, PPU register writes)
//   slave  : system side (CPU bus decoder, RAM, PPU register block)
interface ppu_oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic        cpu_rdy;
  logic        dma_busy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        ppu_cs_n;
  logic        ppu_we;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_data;

  modport master (
    input  cpu_addr, cpu_data, cpu_wr, mem_rdata,
    output cpu_rdy, dma_busy, mem_addr, mem_rd,
    output ppu_cs_n, ppu_we, ppu_reg_addr, ppu_data
  );

  modport slave (
    output cpu_addr, cpu_data, cpu_wr, mem_rdata,
    input  cpu_rdy, dma_busy, mem_addr, mem_rd,
    input  ppu_cs_n, ppu_we, ppu_reg_addr, ppu_data
  );
endinterface

// File: rtl/ppu_oam_dma.sv
// Purpose: sprite (OAM) DMA initiator. A CPU write to the trigger address halts
//          the CPU and copies 256 bytes from CPU page $XX00-$XXFF into OAMDATA
//          through the PPU register port, one READ/WRITE cycle pair per byte.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ppu_oam_dma_if.master (CPU bus in, cpu_rdy/dma_busy out,
//           RAM read port, PPU register write port)
module ppu_oam_dma #(
  parameter logic [15:0] DMA_TRIG_ADDR = ppu_pkg::DMA_TRIG_ADDR,
  parameter logic [2:0]  OAMDATA_REG   = ppu_pkg::OAMDATA,
  parameter int unsigned NUM_BYTES     = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  ppu_oam_dma_if.master        bus
);
  import ppu_pkg::*;

  dma_state_t           r_state;
  dma_state_t           w_next;
  logic [DMA_IDX_W-1:0] r_page;
  logic [DMA_IDX_W-1:0] r_idx;
  logic                 r_parity;
  logic [15:0]          r_mem_addr;
  logic [7:0]           r_ppu_data;
  logic [2:0]           r_reg_addr;
  logic                 w_trig;
  logic                 w_last;

  assign w_trig = bus.cpu_wr && (bus.cpu_addr == DMA_TRIG_ADDR);
  assign w_last = (r_idx == DMA_IDX_W'(NUM_BYTES - 1));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trig) w_next = HALT;
      // Odd get/put phase needs one extra cycle to align the first read
      HALT:    w_next = r_parity ? ALIGN : READ;
      ALIGN:   w_next = READ;
      READ:    w_next = WRITE;
      WRITE:   w_next = w_last ? DONE : READ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, counters and held output values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_page     <= '0;
      r_idx      <= '0;
      r_parity   <= 1'b0;
      r_mem_addr <= '0;
      r_ppu_data <= '0;
      r_reg_addr <= '0;
    end else begin
      r_state  <= w_next;
      r_parity <= ~r_parity;
      if ((r_state == IDLE) && w_trig) begin
        r_page <= bus.cpu_data;
        r_idx  <= '0;
      end
      if (r_state == READ) begin
        r_mem_addr <= {r_page, r_idx};
      end
      if (r_state == WRITE) begin
        r_ppu_data <= bus.mem_rdata;
        r_reg_addr <= OAMDATA_REG;
        // idx stays within the page; it never carries into the page byte
        if (!w_last) r_idx <= r_idx + DMA_IDX_W'(1);
      end
    end
  end

  // Outputs decode the registered state, so async reset drops them at once
  assign bus.cpu_rdy      = (r_state == IDLE);
  assign bus.dma_busy     = (r_state != IDLE);
  assign bus.mem_rd       = (r_state == READ);
  assign bus.mem_addr     = (r_state == READ) ? {r_page, r_idx} : r_mem_addr;
  assign bus.ppu_cs_n     = (r_state != WRITE);
  assign bus.ppu_we       = (r_state == WRITE);
  assign bus.ppu_reg_addr = (r_state == WRITE) ? OAMDATA_REG : r_reg_addr;
  // RAM output is passed straight through during the write cycle
  assign bus.ppu_data     = (r_state == WRITE) ? bus.mem_rdata : r_ppu_data;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Purpose: self-checking bench for ppu_oam_dma with random RAM contents and
//          random pages, against a transfer-level reference model.
module tb_ppu_oam_dma;
  import ppu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ppu_oam_dma_if bus();

  ppu_oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0] ram [65536];
  int n_checks = 0;
  int n_fail   = 0;
  logic tb_par;

  // Get/put phase: flips on every clock while out of reset
  always @(posedge clk or posedge reset) begin
    if (reset) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  // Synchronous RAM: data valid the cycle after the read request
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy"},  32'(bus.cpu_rdy),  32'd1);
    check({tag, "_busy"}, 32'(bus.dma_busy), 32'd0);
    check({tag, "_cs_n"}, 32'(bus.ppu_cs_n), 32'd1);
    check({tag, "_we"},   32'(bus.ppu_we),   32'd0);
    check({tag, "_rd"},   32'(bus.mem_rd),   32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_idle(tag);
    check({tag, "_maddr"}, 32'(bus.mem_addr),     32'd0);
    check({tag, "_pdata"}, 32'(bus.ppu_data),     32'd0);
    check({tag, "_preg"},  32'(bus.ppu_reg_addr), 32'd0);
  endtask

  // One transfer from 'page'; HALT parity forced to halt_par.
  // junk: issue a $4014=$07 write mid-transfer. rst_at>=0: reset during that write.
  task automatic run_dma(input logic [7:0] page, input bit halt_par, input bit junk,
                         input int rst_at);
    int  rd_i = 0;
    int  wr_i = 0;
    int  low  = 0;
    int  cyc  = 0;
    bit  prev_cs = 1'b1;
    bit  done = 1'b0;
    @(negedge clk);
    // Trigger edge sees tb_par; HALT then sees its complement
    if (tb_par == halt_par) @(negedge clk);
    bus.cpu_addr = DMA_TRIG_ADDR;
    bus.cpu_data = page;
    bus.cpu_wr   = 1'b1;
    @(negedge clk);
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 16'h0000;
    check("halt_busy", 32'(bus.dma_busy), 32'd1);
    while (!done && cyc < 700) begin
      if (!bus.cpu_rdy) low++;
      else done = 1'b1;
      if (bus.mem_rd) begin
        check("rd_addr", 32'(bus.mem_addr), 32'({page, 8'(rd_i)}));
        rd_i++;
      end
      if (prev_cs && !bus.ppu_cs_n) begin
        check("wr_we",   32'(bus.ppu_we),       32'd1);
        check("wr_reg",  32'(bus.ppu_reg_addr), 32'(OAMDATA));
        check("wr_data", 32'(bus.ppu_data),     32'(ram[{page, 8'(wr_i)}]));
        if (wr_i == rst_at) begin
          reset = 1'b1;
          #1;
          check_reset_vals("midrst");
          @(negedge clk);
          check_reset_vals("midrst_hold");
          reset = 1'b0;
          return;
        end
        wr_i++;
      end
      prev_cs = bus.ppu_cs_n;
      if (junk && cyc == 50) begin
        bus.cpu_addr = DMA_TRIG_ADDR;
        bus.cpu_data = 8'h07;
        bus.cpu_wr   = 1'b1;
      end else begin
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 16'h0000;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("timeout",  32'(done), 32'd1);
    check("rdy_low",  32'(low),  32'(514 + int'(halt_par)));
    check("n_writes", 32'(wr_i), 32'd256);
    check("n_reads",  32'(rd_i), 32'd256);
    check("addr_hold", 32'(bus.mem_addr), 32'({page, 8'hFF}));
    check_idle("post");
  endtask

  initial begin
    logic [7:0] pg;
    bus.cpu_addr = 16'h0000;
    bus.cpu_data = 8'h00;
    bus.cpu_wr   = 1'b0;
    bus.mem_rdata = 8'h00;
    for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;

    // Trigger while held in reset must be ignored
    @(negedge clk);
    bus.cpu_addr = DMA_TRIG_ADDR;
    bus.cpu_wr   = 1'b1;
    @(negedge clk);
    bus.cpu_wr   = 1'b0;
    check_reset_vals("reset");
    reset = 1'b0;

    // Write to a neighbouring address: no activity
    @(negedge clk);
    bus.cpu_addr = 16'h4015;
    bus.cpu_data = 8'h02;
    bus.cpu_wr   = 1'b1;
    @(negedge clk);
    bus.cpu_wr   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_idle("ign4015");
      @(negedge clk);
    end

    run_dma(8'h02, 1'b0, 1'b0, -1);
    run_dma(8'h02, 1'b1, 1'b0, -1);
    run_dma(8'h03, 1'($urandom_range(0, 1)), 1'b1, -1);
    run_dma(8'h05, 1'($urandom_range(0, 1)), 1'b0, 100);
    run_dma(8'h04, 1'($urandom_range(0, 1)), 1'b0, -1);
    run_dma(8'hFF, 1'b1, 1'b0, -1);
    for (int t = 0; t < 2; t++) begin
      pg = 8'($urandom_range(0, 255));
      run_dma(pg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
